// File: rtl/audio_receiver_if.sv
// -----------------------------------------------------------------------------
// audio_receiver_if
//  Bundles the signals of the audio receiver: the MAC receive byte stream, the
//  PCM playback strobe, the PCM sample output and the frame/underrun counters.
//  master : the surrounding system (drives MAC bytes and pcm_stb)
//  slave  : the audio_receiver itself
// -----------------------------------------------------------------------------
interface audio_receiver_if;
  logic        rx_stb;       // one received byte valid
  logic        rx_sof;       // with rx_stb: frame byte 0
  logic [7:0]  rx_data;      // received byte
  logic        rx_eof;       // end of frame, never with rx_stb
  logic        rx_crc_ok;    // valid with rx_eof
  logic        pcm_stb;      // playback tick
  logic        pcm_valid;    // pcm_chan/pcm_data valid
  logic [2:0]  pcm_chan;     // channel of pcm_data
  logic [15:0] pcm_data;     // signed sample
  logic [15:0] frames_ok;    // committed frames (wraps)
  logic [15:0] frames_drop;  // rejected frames (wraps)
  logic [15:0] underruns;    // strobes with nothing to play (wraps)

  modport master (
    output rx_stb, rx_sof, rx_data, rx_eof, rx_crc_ok, pcm_stb,
    input  pcm_valid, pcm_chan, pcm_data, frames_ok, frames_drop, underruns
  );

  modport slave (
    input  rx_stb, rx_sof, rx_data, rx_eof, rx_crc_ok, pcm_stb,
    output pcm_valid, pcm_chan, pcm_data, frames_ok, frames_drop, underruns
  );
endinterface

// File: rtl/audio_receiver.sv
// -----------------------------------------------------------------------------
// audio_receiver
//  Far end of the audio-over-Ethernet link. Validates each received frame
//  (length, EtherType, FCS), stores its NTICK x NCHAN 16-bit PCM payload into
//  one of two ping-pong banks and replays one tick (NCHAN samples) per
//  pcm_stb, banks played strictly in commit order.
//  Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - audio_receiver_if.slave (MAC bytes in, PCM samples and counters out)
// -----------------------------------------------------------------------------
module audio_receiver #(
  parameter int          HDR_LEN   = 14,
  parameter int          NCHAN     = 8,
  parameter int          NTICK     = 32,
  parameter logic [15:0] ETHERTYPE = 16'h88b5
) (
  input logic              clk,
  input logic              rst,
  audio_receiver_if.slave  bus
);
  localparam int WORDS     = NTICK * NCHAN;          // samples per frame
  localparam int FRAME_LEN = HDR_LEN + 2 * WORDS;    // bytes in a good frame
  localparam int AW        = $clog2(WORDS);
  localparam int CW        = $clog2(NCHAN);
  localparam int TW        = $clog2(NTICK);
  localparam int BW        = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {W_IDLE, W_HDR, W_PAY, W_DROP} wr_state_t;
  typedef enum logic       {P_IDLE, P_EMIT}               pb_state_t;

  // ---------------------------------------------------------------- bank FIFO
  // Full banks are kept as a 2-entry queue of bank indices; the head is the
  // bank being played (or the next one to play).
  logic       q0_reg, q1_reg;
  logic [1:0] q_cnt_reg;
  logic [1:0] bank_full;

  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign bank_full[gi] = (q_cnt_reg != 2'd0 && q0_reg == 1'(gi)) ||
                           (q_cnt_reg == 2'd2 && q1_reg == 1'(gi));
  end

  // ------------------------------------------------------------ write side
  wr_state_t      wr_state_reg;
  logic           wr_bank_reg;
  logic           wr_has_bank_reg;
  logic           type_hi_ok_reg;
  logic           type_ok_reg;
  logic [BW-1:0]  byte_cnt_reg;      // index of the next byte in the frame
  logic [7:0]     lo_byte_reg;       // even payload byte waiting for its partner
  logic [15:0]    frames_ok_reg;
  logic [15:0]    frames_drop_reg;

  logic [AW:0] pay_off;              // payload offset of the current byte
  logic        commit;
  logic        wr_en;
  logic [AW:0] wr_addr;

  assign pay_off = (AW + 1)'(byte_cnt_reg - BW'(HDR_LEN));
  assign commit  = bus.rx_eof && wr_state_reg == W_PAY &&
                   byte_cnt_reg == BW'(FRAME_LEN) && type_ok_reg && bus.rx_crc_ok;
  assign wr_en   = bus.rx_stb && !bus.rx_sof && wr_state_reg == W_PAY &&
                   byte_cnt_reg != BW'(FRAME_LEN) && pay_off[0];
  assign wr_addr = {wr_bank_reg, pay_off[AW:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg    <= W_IDLE;
      wr_bank_reg     <= 1'b0;
      wr_has_bank_reg <= 1'b0;
      type_hi_ok_reg  <= 1'b0;
      type_ok_reg     <= 1'b0;
      byte_cnt_reg    <= '0;
      lo_byte_reg     <= '0;
      frames_ok_reg   <= '0;
      frames_drop_reg <= '0;
    end else if (bus.rx_stb && bus.rx_sof) begin
      // A new frame aborts whatever was in progress
      if (wr_state_reg != W_IDLE) frames_drop_reg <= frames_drop_reg + 16'd1;
      byte_cnt_reg   <= BW'(1);
      type_hi_ok_reg <= 1'b0;
      type_ok_reg    <= 1'b0;
      if (wr_state_reg != W_IDLE && wr_has_bank_reg) begin
        wr_state_reg <= W_HDR;                  // restart in the bank already held
      end else if (!(&bank_full)) begin
        wr_bank_reg     <= bank_full[0];        // lowest empty bank
        wr_has_bank_reg <= 1'b1;
        wr_state_reg    <= W_HDR;
      end else begin
        wr_has_bank_reg <= 1'b0;
        wr_state_reg    <= W_DROP;
      end
    end else if (bus.rx_eof) begin
      if (commit)                     frames_ok_reg   <= frames_ok_reg + 16'd1;
      else if (wr_state_reg != W_IDLE) frames_drop_reg <= frames_drop_reg + 16'd1;
      wr_state_reg    <= W_IDLE;
      wr_has_bank_reg <= 1'b0;
    end else if (bus.rx_stb) begin
      case (wr_state_reg)
        W_HDR: begin
          byte_cnt_reg <= byte_cnt_reg + BW'(1);
          if (byte_cnt_reg == BW'(HDR_LEN - 2))
            type_hi_ok_reg <= (bus.rx_data == ETHERTYPE[15:8]);
          if (byte_cnt_reg == BW'(HDR_LEN - 1)) begin
            type_ok_reg  <= type_hi_ok_reg && (bus.rx_data == ETHERTYPE[7:0]);
            wr_state_reg <= W_PAY;
          end
        end
        W_PAY: begin
          if (byte_cnt_reg == BW'(FRAME_LEN)) begin
            wr_state_reg <= W_DROP;             // frame too long
          end else begin
            byte_cnt_reg <= byte_cnt_reg + BW'(1);
            if (!pay_off[0]) lo_byte_reg <= bus.rx_data;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------- playback side
  pb_state_t      pb_state_reg;
  logic [CW-1:0]  pb_chan_reg;
  logic [TW-1:0]  pb_tick_reg;
  logic           pb_zero_reg;       // this burst is an underrun (zeros)
  logic           pcm_valid_reg;
  logic [CW-1:0]  pcm_chan_reg;
  logic [15:0]    pcm_data_reg;
  logic [15:0]    underruns_reg;

  logic        release_bank;
  logic [AW:0] rd_addr;

  assign release_bank = pb_state_reg == P_EMIT && !pb_zero_reg &&
                        pb_chan_reg == CW'(NCHAN - 1) && pb_tick_reg == TW'(NTICK - 1);
  assign rd_addr      = {q0_reg, AW'(pb_tick_reg * NCHAN + pb_chan_reg)};

  always_ff @(posedge clk) begin
    if (rst) begin
      pb_state_reg  <= P_IDLE;
      pb_chan_reg   <= '0;
      pb_tick_reg   <= '0;
      pb_zero_reg   <= 1'b0;
      pcm_valid_reg <= 1'b0;
      pcm_chan_reg  <= '0;
      underruns_reg <= '0;
    end else begin
      // Output flags trail the read address by one cycle to line up with BRAM data
      pcm_valid_reg <= (pb_state_reg == P_EMIT);
      if (pb_state_reg == P_EMIT) pcm_chan_reg <= pb_chan_reg;
      case (pb_state_reg)
        P_IDLE: begin
          if (bus.pcm_stb) begin
            pb_state_reg <= P_EMIT;
            pb_chan_reg  <= '0;
            pb_zero_reg  <= (q_cnt_reg == 2'd0);
            if (q_cnt_reg == 2'd0) underruns_reg <= underruns_reg + 16'd1;
          end
        end
        default: begin
          if (pb_chan_reg == CW'(NCHAN - 1)) begin
            pb_state_reg <= P_IDLE;
            pb_chan_reg  <= '0;
            if (!pb_zero_reg)
              pb_tick_reg <= (pb_tick_reg == TW'(NTICK - 1)) ? '0 : pb_tick_reg + TW'(1);
          end else begin
            pb_chan_reg <= pb_chan_reg + CW'(1);
          end
        end
      endcase
    end
  end

  // Queue update: commit pushes the write bank, release pops the head; they
  // always refer to different banks, so both can happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q0_reg    <= 1'b0;
      q1_reg    <= 1'b0;
      q_cnt_reg <= 2'd0;
    end else if (commit && release_bank) begin
      if (q_cnt_reg == 2'd2) begin
        q0_reg <= q1_reg;
        q1_reg <= wr_bank_reg;
      end else begin
        q0_reg <= wr_bank_reg;
      end
    end else if (release_bank) begin
      q0_reg    <= q1_reg;
      q_cnt_reg <= q_cnt_reg - 2'd1;
    end else if (commit) begin
      if (q_cnt_reg == 2'd0) q0_reg <= wr_bank_reg;
      else                   q1_reg <= wr_bank_reg;
      q_cnt_reg <= q_cnt_reg + 2'd1;
    end
  end

  // ------------------------------------------------------------ sample store
  logic [15:0] mem [0:2*WORDS-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {bus.rx_data, lo_byte_reg};
  end

  always_ff @(posedge clk) begin
    if (rst)                         pcm_data_reg <= '0;
    else if (pb_state_reg == P_EMIT) pcm_data_reg <= pb_zero_reg ? 16'd0 : mem[rd_addr];
  end

  assign bus.pcm_valid   = pcm_valid_reg;
  assign bus.pcm_chan    = pcm_chan_reg;
  assign bus.pcm_data    = pcm_data_reg;
  assign bus.frames_ok   = frames_ok_reg;
  assign bus.frames_drop = frames_drop_reg;
  assign bus.underruns   = underruns_reg;
endmodule

// File: tb/tb_audio_receiver.sv
// -----------------------------------------------------------------------------
// tb_audio_receiver
//  Randomized bench for audio_receiver. A reference model keeps the committed
//  frames as a FIFO of sample arrays plus a tick index, and expected counters.
// -----------------------------------------------------------------------------
module tb_audio_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_receiver_if bus ();
  audio_receiver dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  // reference model
  int          exp_ok, exp_drop, exp_under;
  logic [15:0] mfr [0:1][0:255];   // ring of committed frames
  int          m_head, m_cnt, m_tick;
  logic [15:0] fb [0:255];         // payload of the frame about to be sent

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_ok = 0; exp_drop = 0; exp_under = 0;
    m_head = 0; m_cnt = 0; m_tick = 0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ":frames_ok"},   bus.frames_ok,   32'(exp_ok % 65536));
    check({tag, ":frames_drop"}, bus.frames_drop, 32'(exp_drop % 65536));
    check({tag, ":underruns"},   bus.underruns,   32'(exp_under % 65536));
  endtask

  task automatic do_reset();
    bus.rx_stb = 0; bus.rx_sof = 0; bus.rx_data = 0; bus.rx_eof = 0;
    bus.rx_crc_ok = 0; bus.pcm_stb = 0;
    rst = 1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 0;
    model_reset();
  endtask

  task automatic fill_frame(input bit pattern);
    for (int k = 0; k < 256; k++) fb[k] = pattern ? 16'(16'h0100 + k) : 16'($urandom);
  endtask

  // Sends one frame; abort_at >= 0 pulses rst instead of sending that byte.
  task automatic send_frame(input int len, input logic [15:0] etype, input logic crc,
                            input int abort_at);
    logic [7:0]  b;
    logic [15:0] w;
    bit          has_bank;
    has_bank = (m_cnt < 2);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        bus.rx_stb = 0; bus.rx_sof = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        $display("frame len=%0d aborted by reset at byte %0d", len, i);
        return;
      end
      if (i == 12)      b = etype[15:8];
      else if (i == 13) b = etype[7:0];
      else if (i >= 14 && i < 526) begin
        w = fb[(i - 14) / 2];
        b = ((i - 14) % 2 == 1) ? w[15:8] : w[7:0];
      end else b = 8'($urandom_range(0, 255));
      bus.rx_stb = 1; bus.rx_sof = (i == 0); bus.rx_data = b;
      @(posedge clk); #1;
    end
    bus.rx_stb = 0; bus.rx_sof = 0; bus.rx_eof = 1; bus.rx_crc_ok = crc;
    @(posedge clk); #1;
    bus.rx_eof = 0; bus.rx_crc_ok = 0;
    if (has_bank && len == 526 && etype == 16'h88b5 && crc) begin
      for (int k = 0; k < 256; k++) mfr[(m_head + m_cnt) % 2][k] = fb[k];
      m_cnt++;
      exp_ok++;
    end else exp_drop++;
    $display("frame len=%0d type=%04h crc=%0d expect %s", len, etype, crc,
             (exp_ok > 0 && has_bank && len == 526 && etype == 16'h88b5 && crc) ? "commit" : "drop");
  endtask

  // One playback strobe with cycle-exact checks; dup re-strobes mid-burst.
  task automatic strobe(input bit dup);
    logic [15:0] exp_d [0:7];
    bit          zero;
    zero = (m_cnt == 0);
    for (int c = 0; c < 8; c++) exp_d[c] = zero ? 16'd0 : mfr[m_head][m_tick * 8 + c];
    if (zero) exp_under++;
    bus.pcm_stb = 1;
    @(posedge clk); #1;
    bus.pcm_stb = 0;
    check("valid_early", bus.pcm_valid, 0);
    for (int c = 0; c < 8; c++) begin
      bus.pcm_stb = (dup && c == 2);
      @(posedge clk); #1;
      bus.pcm_stb = 0;
      check("pcm_valid", bus.pcm_valid, 1);
      check("pcm_chan",  bus.pcm_chan,  c);
      check("pcm_data",  bus.pcm_data,  exp_d[c]);
    end
    @(posedge clk); #1;
    check("valid_late", bus.pcm_valid, 0);
    $display("strobe tick=%0d %s dup=%0d", m_tick, zero ? "underrun" : "play", dup);
    if (!zero) begin
      m_tick++;
      if (m_tick == 32) begin
        m_tick = 0; m_head = (m_head + 1) % 2; m_cnt--;
      end
    end
  endtask

  initial begin
    int op, len;
    logic [15:0] et;
    logic crc;

    // 1: reset state and underruns
    do_reset();
    check("rst:pcm_valid", bus.pcm_valid, 0);
    check("rst:pcm_chan",  bus.pcm_chan,  0);
    check("rst:pcm_data",  bus.pcm_data,  0);
    check_counters("rst");
    repeat (3) strobe(0);
    check_counters("t1");

    // 2: one good frame with a known ramp, played out plus one underrun
    do_reset();
    fill_frame(1);
    send_frame(526, 16'h88b5, 1, -1);
    check_counters("t2_frame");
    repeat (33) strobe(0);
    check_counters("t2_play");

    // 3: bad CRC, short, long, wrong type
    do_reset();
    fill_frame(0); send_frame(526, 16'h88b5, 0, -1);
    fill_frame(0); send_frame(525, 16'h88b5, 1, -1);
    fill_frame(0); send_frame(527, 16'h88b5, 1, -1);
    fill_frame(0); send_frame(526, 16'h0800, 1, -1);
    check_counters("t3_frames");
    strobe(0);
    check_counters("t3_play");

    // 4: three back-to-back good frames, third has no bank
    do_reset();
    repeat (3) begin fill_frame(0); send_frame(526, 16'h88b5, 1, -1); end
    check_counters("t4_frames");
    repeat (65) strobe(0);
    check_counters("t4_play");

    // 5: commit on the same cycle as release of the other bank
    do_reset();
    fill_frame(0); send_frame(526, 16'h88b5, 1, -1);
    repeat (31) strobe(0);
    fill_frame(0);
    fork
      send_frame(526, 16'h88b5, 1, -1);   // eof lands on cycle S+526
      begin
        repeat (518) begin @(posedge clk); #1; end
        strobe(0);                        // last read/release on cycle T+8 = S+526
      end
    join
    check_counters("t5_commit");
    repeat (3) strobe(0);
    check_counters("t5_play");

    // 6: reset in the middle of the payload, then a good frame
    do_reset();
    fill_frame(0); send_frame(526, 16'h88b5, 1, 14 + 200);
    check_counters("t6_abort");
    fill_frame(1); send_frame(526, 16'h88b5, 1, -1);
    check_counters("t6_frame");
    repeat (33) strobe(0);
    check_counters("t6_play");

    // 7: randomized mix of frames and strobes
    do_reset();
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      if (op < 3) begin
        case ($urandom_range(0, 7))
          0:       len = 525;
          1:       len = 527;
          2:       len = 20;
          default: len = 526;
        endcase
        et  = ($urandom_range(0, 7) == 0) ? 16'h88b4 : 16'h88b5;
        crc = ($urandom_range(0, 7) != 0);
        fill_frame(0);
        send_frame(len, et, crc, -1);
      end else begin
        repeat ($urandom_range(1, 6)) strobe($urandom_range(0, 3) == 0);
      end
      check_counters("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
